mac_rx_ring: RTL and testbench

Parametrised Ethernet receive MAC for the GbE readout path: detects preamble/SFD on an MII (4-bit) or GMII (8-bit) PHY interface, assembles bytes, checks length and FCS, and stores accepted frames in an N-slot ring buffer. Successor to the single-frame nibble receiver: it adds a configurable PHY width, multi-frame buffering with explicit frame release, RXER handling, and drop/error counters. It sits between the PHY pins and the command/packet parser, which reads frames by address.

---
 rtl/mac_rx_pkg.sv | 30 +++
 rtl/mac_crc32_d8.sv | 38 +++
 rtl/mac_rx_ring.sv | 198 +++++++++++++++++++
 tb/tb_mac_rx_ring.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_rx_pkg.sv
// mac_rx_pkg: shared types and constants for the mac_rx_ring receive MAC.
//   wr_state_e   : write-side FSM state encoding (exposed on dbg_state_o)
//   *_NIB/_BYTE  : preamble / SFD patterns for MII (nibble) and GMII (byte)
//   CRC_RESIDUE  : CRC-32 good-frame residue, normal (MSB-first) bit order
//   CRC_POLY     : CRC-32 generator polynomial, normal bit order
//   reflect32()  : bit-reverse helper used to move between bit orders
package mac_rx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } wr_state_e;

  localparam logic [3:0]  PREAMBLE_NIB  = 4'h5;
  localparam logic [3:0]  SFD_NIB       = 4'hD;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/mac_crc32_d8.sv
// mac_crc32_d8: byte-wide reflected CRC-32 (Ethernet FCS), init 0xFFFFFFFF,
// no output inversion. Only instantiated when MAC_RX_CRC_CHECK_EN is defined.
//   clk_i, rst_ni : clock, async active-low reset
//   init_i        : reload the register with 0xFFFFFFFF (priority over en_i)
//   en_i, data_i  : fold one byte into the register
//   crc_o         : current register value (reflected bit order)
module mac_crc32_d8
  import mac_rx_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  // Reflected form shifts right, so the polynomial is bit-reversed too.
  localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ POLY_REFL) : (r >> 1);
    return r;
  endfunction

  logic [31:0] crc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     crc_q <= 32'hFFFF_FFFF;
    else if (init_i) crc_q <= 32'hFFFF_FFFF;
    else if (en_i)   crc_q <= crc_byte(crc_q, data_i);
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/mac_rx_ring.sv
// mac_rx_ring: Ethernet receive MAC (MII or GMII) feeding an NSLOT frame ring.
// Optional feature macro: MAC_RX_CRC_CHECK_EN (FCS check present when defined;
// otherwise every frame of legal length is committed).
// Ports:
//   PHY_RXC, reset_n          : sole clock, async active-low reset
//   PHY_RXD/RXDV/RXER         : PHY receive bus (MII: low nibble first)
//   Rd_en, Rd_Addr, Rd_data   : registered byte read from the head slot
//   Frm_valid, Frm_len        : head frame present / its length incl. FCS
//   Frm_done                  : one-cycle pulse releasing the head slot
//   Drop_cnt, Crc_err_cnt     : saturating drop / FCS+runt error counters
//   dbg_state_o               : write FSM state
// Handshake: Frm_done is accepted on a clock edge only while the ring holds
// a committed frame; there is no backpressure toward the PHY, frames that
// cannot be stored are dropped and counted.
module mac_rx_ring
  import mac_rx_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int SLOT_AW = 11,
  parameter int NSLOT   = 4,
  parameter int MIN_LEN = 64
) (
  input  logic               PHY_RXC,
  input  logic               reset_n,
  input  logic [DATA_W-1:0]  PHY_RXD,
  input  logic               PHY_RXDV,
  input  logic               PHY_RXER,
  input  logic               Rd_en,
  input  logic [SLOT_AW-1:0] Rd_Addr,
  output logic [7:0]         Rd_data,
  output logic               Frm_valid,
  output logic [SLOT_AW:0]   Frm_len,
  input  logic               Frm_done,
  output logic [15:0]        Drop_cnt,
  output logic [15:0]        Crc_err_cnt,
  output logic [1:0]         dbg_state_o
);

  localparam int PW = $clog2(NSLOT);
  localparam int CW = PW + 1;
  localparam bit IS_MII = (DATA_W == 4);
  localparam logic [SLOT_AW:0] SLOT_BYTES = {1'b1, {SLOT_AW{1'b0}}};
  localparam logic [SLOT_AW:0] MIN_LEN_C  = (SLOT_AW+1)'(MIN_LEN);
  localparam logic [CW-1:0]    NSLOT_C    = CW'(NSLOT);

  wr_state_e        state_q, state_d;
  logic [SLOT_AW:0] byte_cnt_q, byte_cnt_d;
  logic             phase_q, phase_d;   // MII: low nibble already captured
  logic [3:0]       nib_q, nib_d;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [SLOT_AW:0] len_q [NSLOT];
  logic [7:0]       mem [NSLOT * (2**SLOT_AW)];
  logic             frm_valid_q;
  logic [SLOT_AW:0] frm_len_q;
  logic [7:0]       rd_data_q;
  logic [15:0]      drop_cnt_q, crc_err_cnt_q;

  logic       is_pre, is_sfd, byte_done, crc_ok;
  logic [7:0] wbyte;
  logic       we, commit, drop_inc, crcerr_inc, crc_init, accept_done;

  if (IS_MII) begin : g_mii
    assign is_pre = (PHY_RXD[3:0] == PREAMBLE_NIB);
    assign is_sfd = (PHY_RXD[3:0] == SFD_NIB);
    assign wbyte  = {PHY_RXD[3:0], nib_q};
  end else begin : g_gmii
    logic unused_nib;
    assign unused_nib = ^nib_q;
    assign is_pre = (PHY_RXD[7:0] == PREAMBLE_BYTE);
    assign is_sfd = (PHY_RXD[7:0] == SFD_BYTE);
    assign wbyte  = PHY_RXD[7:0];
  end

  // In MII a byte completes on the second (high) nibble.
  assign byte_done = IS_MII ? phase_q : 1'b1;

`ifdef MAC_RX_CRC_CHECK_EN
  logic [31:0] crc_w;
  mac_crc32_d8 u_crc (
    .clk_i  (PHY_RXC),
    .rst_ni (reset_n),
    .init_i (crc_init),
    .en_i   (we),
    .data_i (wbyte),
    .crc_o  (crc_w)
  );
  // Register is kept reflected, so compare against the reflected residue.
  assign crc_ok = (crc_w == reflect32(CRC_RESIDUE));
`else
  logic unused_crc_init;
  assign unused_crc_init = crc_init;
  assign crc_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    phase_d    = phase_q;
    nib_d      = nib_q;
    we         = 1'b0;
    commit     = 1'b0;
    drop_inc   = 1'b0;
    crcerr_inc = 1'b0;
    crc_init   = 1'b0;
    unique case (state_q)
      IDLE: if (PHY_RXDV && is_pre) state_d = PREAMBLE;
      PREAMBLE: begin
        if (!PHY_RXDV) state_d = IDLE;
        else if (is_sfd) begin
          if (count_q != NSLOT_C) begin
            state_d    = DATA;
            byte_cnt_d = '0;
            phase_d    = 1'b0;
            crc_init   = 1'b1;
          end else begin
            state_d  = DROP;
            drop_inc = 1'b1;
          end
        end else if (!is_pre) state_d = IDLE;
      end
      DATA: begin
        if (!PHY_RXDV) begin
          // A dangling MII nibble never reached byte_cnt, so it is ignored here.
          if (byte_cnt_q >= MIN_LEN_C && crc_ok) commit = 1'b1;
          else                                   crcerr_inc = 1'b1;
          state_d = IDLE;
        end else if (PHY_RXER) begin
          state_d  = DROP;
          drop_inc = 1'b1;
        end else if (!byte_done) begin
          nib_d   = PHY_RXD[3:0];
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (byte_cnt_q == SLOT_BYTES) begin
            state_d  = DROP;
            drop_inc = 1'b1;
          end else begin
            we         = 1'b1;
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      DROP: if (!PHY_RXDV) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept_done = Frm_done && (count_q != '0);
  assign count_d     = count_q + CW'(commit) - CW'(accept_done);

  always_ff @(posedge PHY_RXC or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      byte_cnt_q    <= '0;
      phase_q       <= 1'b0;
      nib_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < NSLOT; i++) len_q[i] <= '0;
      frm_valid_q   <= 1'b0;
      frm_len_q     <= '0;
      rd_data_q     <= 8'h00;
      drop_cnt_q    <= '0;
      crc_err_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      phase_q    <= phase_d;
      nib_q      <= nib_d;
      wr_ptr_q   <= wr_ptr_q + PW'(commit);
      rd_ptr_q   <= rd_ptr_q + PW'(accept_done);
      count_q    <= count_d;
      if (commit) len_q[wr_ptr_q] <= byte_cnt_q;
      // Head status is registered from the previous cycle's ring state.
      frm_valid_q <= (count_q != '0);
      frm_len_q   <= len_q[rd_ptr_q];
      if (Rd_en) rd_data_q <= mem[{rd_ptr_q, Rd_Addr}];
      if (drop_inc && drop_cnt_q != 16'hFFFF)      drop_cnt_q    <= drop_cnt_q + 16'd1;
      if (crcerr_inc && crc_err_cnt_q != 16'hFFFF) crc_err_cnt_q <= crc_err_cnt_q + 16'd1;
    end
  end

  // Frame RAM: no reset, written only with whole bytes in DATA.
  always_ff @(posedge PHY_RXC) begin
    if (we) mem[{wr_ptr_q, byte_cnt_q[SLOT_AW-1:0]}] <= wbyte;
  end

  assign Rd_data     = rd_data_q;
  assign Frm_valid   = frm_valid_q;
  assign Frm_len     = frm_len_q;
  assign Drop_cnt    = drop_cnt_q;
  assign Crc_err_cnt = crc_err_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mac_rx_ring.sv
// tb_mac_rx_ring: directed bench for mac_rx_ring with one MII instance
// (DATA_W=4, SLOT_AW=11) and one GMII instance (DATA_W=8, SLOT_AW=7, NSLOT=4).
module tb_mac_rx_ring;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- MII instance ----------------
  logic [3:0]  m_rxd = '0;
  logic        m_rxdv = 1'b0, m_rxer = 1'b0, m_rd_en = 1'b0, m_done = 1'b0;
  logic [10:0] m_rd_addr = '0;
  logic [7:0]  m_rd_data;
  logic        m_valid;
  logic [11:0] m_len;
  logic [15:0] m_drop, m_crc;
  logic [1:0]  m_state;

  mac_rx_ring #(.DATA_W(4), .SLOT_AW(11), .NSLOT(4), .MIN_LEN(64)) u_mii (
    .PHY_RXC(clk), .reset_n(reset_n), .PHY_RXD(m_rxd), .PHY_RXDV(m_rxdv),
    .PHY_RXER(m_rxer), .Rd_en(m_rd_en), .Rd_Addr(m_rd_addr), .Rd_data(m_rd_data),
    .Frm_valid(m_valid), .Frm_len(m_len), .Frm_done(m_done), .Drop_cnt(m_drop),
    .Crc_err_cnt(m_crc), .dbg_state_o(m_state)
  );

  // ---------------- GMII instance ----------------
  logic [7:0]  g_rxd = '0;
  logic        g_rxdv = 1'b0, g_rxer = 1'b0, g_rd_en = 1'b0, g_done = 1'b0;
  logic [6:0]  g_rd_addr = '0;
  logic [7:0]  g_rd_data;
  logic        g_valid;
  logic [7:0]  g_len;
  logic [15:0] g_drop, g_crc;
  logic [1:0]  g_state;

  mac_rx_ring #(.DATA_W(8), .SLOT_AW(7), .NSLOT(4), .MIN_LEN(64)) u_gmii (
    .PHY_RXC(clk), .reset_n(reset_n), .PHY_RXD(g_rxd), .PHY_RXDV(g_rxdv),
    .PHY_RXER(g_rxer), .Rd_en(g_rd_en), .Rd_Addr(g_rd_addr), .Rd_data(g_rd_data),
    .Frm_valid(g_valid), .Frm_len(g_len), .Frm_done(g_done), .Drop_cnt(g_drop),
    .Crc_err_cnt(g_crc), .dbg_state_o(g_state)
  );

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_q[$];      // expected read bytes
  logic [11:0] exp_len_q[$];  // expected head-frame lengths, in commit order
  logic [7:0]  frm[$];        // frame under construction (payload + FCS)
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Independent bitwise model of the Ethernet CRC-32 (reflected, poly 0xEDB88320).
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Frame of len bytes incl. FCS: 9 x tag, 02 00 01 00, zeros, FCS little-endian.
  task automatic build(input int len, input logic [7:0] tag);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFF_FFFF;
    frm.delete();
    for (int i = 0; i < len - 4; i++) begin
      if (i < 9)        b = tag;
      else if (i == 9)  b = 8'h02;
      else if (i == 11) b = 8'h01;
      else              b = 8'h00;
      frm.push_back(b);
      c = crc_upd(c, b);
    end
    c = ~c;
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends 7x55 + D5 + frm. rxer_idx >= 0 raises RXER on that frame byte (GMII).
  // done_end raises Frm_done on the cycle whose edge commits the frame.
  task automatic send(input bit mii, input bit extra_nib, input int rxer_idx, input bit done_end);
    logic [7:0] b;
    for (int i = 0; i < 8 + frm.size(); i++) begin
      b = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : frm[i-8];
      if (mii) begin
        @(negedge clk); m_rxdv = 1'b1; m_rxd = b[3:0];
        @(negedge clk); m_rxd = b[7:4];
      end else begin
        @(negedge clk); g_rxdv = 1'b1; g_rxd = b;
        g_rxer = (rxer_idx >= 0) && (i - 8 == rxer_idx);
      end
    end
    if (mii && extra_nib) begin
      @(negedge clk); m_rxd = 4'h7;
    end
    @(negedge clk);
    m_rxdv = 1'b0; g_rxdv = 1'b0; g_rxer = 1'b0;
    if (mii) m_done = done_end; else g_done = done_end;
    @(negedge clk);
    m_done = 1'b0; g_done = 1'b0;
    wait_cyc(2);
  endtask

  task automatic pulse_done(input bit mii);
    @(negedge clk);
    if (mii) m_done = 1'b1; else g_done = 1'b1;
    @(negedge clk);
    m_done = 1'b0; g_done = 1'b0;
    wait_cyc(2);
  endtask

  task automatic rd(input bit mii, input int addr, input logic [7:0] exp, input string name);
    @(negedge clk);
    if (mii) begin m_rd_en = 1'b1; m_rd_addr = 11'(addr); end
    else     begin g_rd_en = 1'b1; g_rd_addr = 7'(addr); end
    exp_q.push_back(exp);
    @(negedge clk);
    m_rd_en = 1'b0; g_rd_en = 1'b0;
    chk(name, mii ? m_rd_data : g_rd_data, exp_q.pop_front());
  endtask

  task automatic head(input bit mii, input logic [7:0] tag, input string name);
    chk({name, "_valid"}, mii ? m_valid : g_valid, 1);
    chk({name, "_len"}, mii ? 32'(m_len) : 32'(g_len), 32'(exp_len_q.pop_front()));
    rd(mii, 0, tag, {name, "_b0"});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    wait_cyc(3);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_len",   m_len, 0);
    chk("rst_m_rd",    m_rd_data, 8'h00);
    chk("rst_m_state", m_state, 0);
    chk("rst_g_drop",  g_drop, 0);
    chk("rst_g_crc",   g_crc, 0);
    chk("rst_g_valid", g_valid, 0);
    reset_n = 1'b1;
    wait_cyc(2);

    // MII good 64-byte frame
    build(64, 8'hAA);
    exp_len_q.push_back(12'd64);
    send(1, 0, -1, 0);
    head(1, 8'hAA, "mii_good");
    rd(1, 9, 8'h02, "mii_good_b9");
    rd(1, 63, frm[63], "mii_good_fcs3");
    pulse_done(1);
    chk("mii_good_released", m_valid, 0);

    // MII same frame, last FCS nibble flipped
    build(64, 8'hAA);
    frm[63] = frm[63] ^ 8'hF0;
`ifdef MAC_RX_CRC_CHECK_EN
    send(1, 0, -1, 0);
    chk("mii_badfcs_valid", m_valid, 0);
    chk("mii_badfcs_crc",   m_crc, 1);
`else
    exp_len_q.push_back(12'd64);
    send(1, 0, -1, 0);
    chk("mii_badfcs_crc", m_crc, 0);
    head(1, 8'hAA, "mii_nocrc");
    pulse_done(1);
`endif

    // MII trailing odd nibble is discarded, frame still accepted
    build(64, 8'h5C);
    exp_len_q.push_back(12'd64);
    send(1, 1, -1, 0);
    head(1, 8'h5C, "mii_oddnib");
    pulse_done(1);
    chk("mii_oddnib_released", m_valid, 0);

    // GMII: five frames into four slots
    for (int f = 0; f < 5; f++) begin
      build(64, 8'(8'h10 + f));
      if (f < 4) exp_len_q.push_back(12'd64);
      send(0, 0, -1, 0);
    end
    chk("full_drop", g_drop, 1);
    chk("full_crc",  g_crc, 0);
    for (int f = 0; f < 4; f++) begin
      head(0, 8'(8'h10 + f), "full_head");
      pulse_done(0);
    end
    chk("full_empty", g_valid, 0);
    pulse_done(0);  // release on an empty ring must be ignored
    chk("empty_done_ignored", g_valid, 0);

    // GMII runt (63 bytes, good FCS)
    build(63, 8'h33);
    send(0, 0, -1, 0);
    chk("runt_crc",   g_crc, 1);
    chk("runt_valid", g_valid, 0);

    // GMII RXER mid-frame
    build(64, 8'h44);
    send(0, 0, 20, 0);
    chk("rxer_drop",  g_drop, 2);
    chk("rxer_crc",   g_crc, 1);
    chk("rxer_valid", g_valid, 0);

    // GMII frame longer than a 128-byte slot
    build(130, 8'h55);
    send(0, 0, -1, 0);
    chk("long_drop",  g_drop, 3);
    chk("long_valid", g_valid, 0);

    // Commit coincident with Frm_done while one frame is held
    build(64, 8'h20);
    exp_len_q.push_back(12'd64);
    send(0, 0, -1, 0);
    chk("coinc_a_valid", g_valid, 1);
    chk("coinc_a_len", g_len, 32'(exp_len_q.pop_front()));
    build(70, 8'h21);
    exp_len_q.push_back(12'd70);
    send(0, 0, -1, 1);
    head(0, 8'h21, "coinc_b");
    pulse_done(0);
    chk("coinc_count_was_1", g_valid, 0);

    // Reset during DATA with two frames held
    build(64, 8'h30); send(0, 0, -1, 0);
    build(64, 8'h31); send(0, 0, -1, 0);
    chk("pre_rst_valid", g_valid, 1);
    build(64, 8'h32);
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      g_rxdv = 1'b1;
      g_rxd  = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : frm[i-8];
    end
    wait_cyc(1);
    chk("pre_rst_state", g_state, 2);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", g_valid, 0);
    chk("rst_mid_drop",  g_drop, 0);
    chk("rst_mid_crc",   g_crc, 0);
    chk("rst_mid_state", g_state, 0);
    g_rxdv = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_cyc(2);
    build(64, 8'h40);
    exp_len_q.push_back(12'd64);
    send(0, 0, -1, 0);
    head(0, 8'h40, "after_rst");
    rd(0, 9, 8'h02, "after_rst_b9");

    chk("sb_len_drained", exp_len_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
